vga_frame_snapshot: RTL and testbench

//  Frame-synchronous snapshot buffer between the elevator core and the VGA controller.

---
 rtl/vga_pkg.sv | 20 ++
 rtl/vga_frame_edge.sv | 22 ++
 rtl/vga_frame_snapshot.sv | 157 +++++++++++++++
 tb/tb_vga_frame_snapshot.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared types and widths for the VGA display path of the elevator project.
package vga_pkg;

    localparam int DEST_W   = 8;
    localparam int PEOPLE_W = 26;

    typedef enum logic [1:0] {
        SIM_IDLE  = 2'd0,
        SIM_RUN   = 2'd1,
        SIM_HOLD  = 2'd2,
        SIM_FAULT = 2'd3
    } sim_state_t;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        IDLE    = 2'd1,
        PENDING = 2'd2
    } snap_state_t;

endpackage

// File: rtl/vga_frame_edge.sv
// Detects the falling edge of the active-low vsync to mark one cycle per frame.
module vga_frame_edge (
    input  logic clk,
    input  logic nrst,
    input  logic vsync,
    output logic frame_tick
);

    logic vsync_q;

    // Delay vsync by one clock; resetting to 0 means a boundary needs vsync seen high first
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            vsync_q <= 1'b0;
        end else begin
            vsync_q <= vsync;
        end
    end

    assign frame_tick = vsync_q & ~vsync;

endmodule

// File: rtl/vga_frame_snapshot.sv
// Frame-synchronous snapshot buffer: core updates land in a shadow register and
// only reach the display outputs at a vsync falling edge, so a frame never tears.
module vga_frame_snapshot
    import vga_pkg::*;
#(
    parameter int unsigned BLINK_BIT    = 3,
    parameter int unsigned STALE_FRAMES = 60
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                upd_valid,
    output logic                upd_ready,
    input  logic [DEST_W-1:0]   destination,
    input  logic [PEOPLE_W-1:0] people_data,
    input  logic [1:0]          sim_state,
    input  logic                vsync,
    output logic [DEST_W-1:0]   disp_destination,
    output logic [PEOPLE_W-1:0] disp_people_data,
    output logic [1:0]          disp_sim_state,
    output logic                disp_valid,
    output logic [7:0]          frame_count,
    output logic                blink,
    output logic                stale
);

    localparam logic [7:0] STALE_LIMIT = 8'(STALE_FRAMES);

    snap_state_t         state_q;
    snap_state_t         state_d;
    logic                frame_tick;
    logic                accept;
    logic                commit;

    logic [DEST_W-1:0]   shadow_dest;
    logic [PEOPLE_W-1:0] shadow_people;
    sim_state_t          shadow_sim;

    logic [DEST_W-1:0]   disp_dest_q;
    logic [PEOPLE_W-1:0] disp_people_q;
    sim_state_t          disp_sim_q;
    logic                disp_valid_q;

    logic [7:0]          frame_cnt_q;
    logic [7:0]          stale_cnt_q;
    logic [7:0]          stale_cnt_d;
    logic                stale_q;

    vga_frame_edge u_frame_edge (
        .clk        (clk),
        .nrst       (nrst),
        .vsync      (vsync),
        .frame_tick (frame_tick)
    );

    // The shadow is free in every state except PENDING
    assign upd_ready = (state_q != PENDING);

    // Snapshot FSM state register
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Accept new words while the shadow is free, commit them on the next frame boundary
    always_comb begin
        state_d = state_q;
        accept  = 1'b0;
        commit  = 1'b0;
        case (state_q)
            EMPTY, IDLE: begin
                if (upd_valid) begin
                    accept  = 1'b1;
                    state_d = PENDING;
                end
            end
            PENDING: begin
                if (frame_tick) begin
                    commit  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Capture the core's state word into the shadow on accept
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            shadow_dest   <= '0;
            shadow_people <= '0;
            shadow_sim    <= SIM_IDLE;
        end else if (accept) begin
            shadow_dest   <= destination;
            shadow_people <= people_data;
            shadow_sim    <= sim_state_t'(sim_state);
        end
    end

    // Display register changes only on a commit edge, keeping it stable across a frame
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            disp_dest_q   <= '0;
            disp_people_q <= '0;
            disp_sim_q    <= SIM_IDLE;
            disp_valid_q  <= 1'b0;
        end else if (commit) begin
            disp_dest_q   <= shadow_dest;
            disp_people_q <= shadow_people;
            disp_sim_q    <= shadow_sim;
            disp_valid_q  <= 1'b1;
        end
    end

    // Count every frame boundary regardless of FSM state; wraps naturally at 8 bits
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            frame_cnt_q <= '0;
        end else if (frame_tick) begin
            frame_cnt_q <= frame_cnt_q + 8'd1;
        end
    end

    // Frames since the last commit, saturating so a long-idle core stays flagged
    always_comb begin
        stale_cnt_d = stale_cnt_q;
        if (commit) begin
            stale_cnt_d = '0;
        end else if (frame_tick && (stale_cnt_q != 8'hFF)) begin
            stale_cnt_d = stale_cnt_q + 8'd1;
        end
    end

    // Stale counter and its registered threshold compare update on the same edge
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            stale_cnt_q <= '0;
            stale_q     <= 1'b0;
        end else begin
            stale_cnt_q <= stale_cnt_d;
            stale_q     <= (stale_cnt_d >= STALE_LIMIT);
        end
    end

    assign disp_destination = disp_dest_q;
    assign disp_people_data = disp_people_q;
    assign disp_sim_state   = disp_sim_q;
    assign disp_valid       = disp_valid_q;
    assign frame_count      = frame_cnt_q;
    assign blink            = frame_cnt_q[BLINK_BIT];
    assign stale            = stale_q;

endmodule

// File: tb/tb_vga_frame_snapshot.sv
// Self-checking bench for vga_frame_snapshot: a scoreboard queue holds accepted
// state words until the bench's own frame model says they should be displayed.
module tb_vga_frame_snapshot;

    typedef struct packed {
        logic [7:0]  d;
        logic [25:0] p;
        logic [1:0]  s;
    } snap_t;

    logic        clk;
    logic        nrst;
    logic        upd_valid;
    logic        upd_ready;
    logic [7:0]  destination;
    logic [25:0] people_data;
    logic [1:0]  sim_state;
    logic        vsync;
    logic [7:0]  disp_destination;
    logic [25:0] disp_people_data;
    logic [1:0]  disp_sim_state;
    logic        disp_valid;
    logic [7:0]  frame_count;
    logic        blink;
    logic        stale;

    int tests_run    = 0;
    int tests_failed = 0;

    snap_t      sb[$];
    snap_t      exp_disp;
    logic       exp_valid;
    logic       model_pending;
    logic [7:0] model_frames;
    int         model_stale_cnt;
    logic [7:0] pre_tick_dest;

    vga_frame_snapshot #(
        .BLINK_BIT    (3),
        .STALE_FRAMES (60)
    ) dut (
        .clk              (clk),
        .nrst             (nrst),
        .upd_valid        (upd_valid),
        .upd_ready        (upd_ready),
        .destination      (destination),
        .people_data      (people_data),
        .sim_state        (sim_state),
        .vsync            (vsync),
        .disp_destination (disp_destination),
        .disp_people_data (disp_people_data),
        .disp_sim_state   (disp_sim_state),
        .disp_valid       (disp_valid),
        .frame_count      (frame_count),
        .blink            (blink),
        .stale            (stale)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: sim time limit reached, run did not finish");
        $fatal(1, "[TB] watchdog");
    end

    task automatic model_reset();
        sb.delete();
        exp_disp        = '0;
        exp_valid       = 1'b0;
        model_pending   = 1'b0;
        model_frames    = 8'd0;
        model_stale_cnt = 0;
    endtask

    // Present one word for a single clock; the model accepts it only if the shadow is free
    task automatic applyStimulus(input snap_t w);
        @(negedge clk);
        upd_valid   = 1'b1;
        destination = w.d;
        people_data = w.p;
        sim_state   = w.s;
        if (!model_pending) begin
            sb.push_back(w);
            model_pending = 1'b1;
        end
        @(negedge clk);
        upd_valid = 1'b0;
    endtask

    // One short frame: vsync high two clocks then a falling edge, optionally with an update on the tick cycle
    task automatic do_frame(input bit with_upd, input snap_t w);
        logic ready_before;
        @(negedge clk);
        vsync = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vsync = 1'b0;
        if (with_upd) begin
            upd_valid   = 1'b1;
            destination = w.d;
            people_data = w.p;
            sim_state   = w.s;
        end
        #1;
        pre_tick_dest = disp_destination;
        ready_before  = !model_pending;
        if (model_pending) begin
            exp_disp        = sb.pop_front();
            exp_valid       = 1'b1;
            model_pending   = 1'b0;
            model_stale_cnt = 0;
        end else if (model_stale_cnt != 255) begin
            model_stale_cnt++;
        end
        if (with_upd && ready_before) begin
            sb.push_back(w);
            model_pending = 1'b1;
        end
        model_frames = model_frames + 8'd1;
        @(negedge clk);
        upd_valid = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        vsync = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        nrst = 1'b1;
        repeat (20) @(negedge clk);
        tests_run++;
        if (frame_count !== 8'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_frame_count: got %0d want 0", frame_count);
        end
        tests_run++;
        if (disp_valid !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_disp_valid: got %b want 0", disp_valid);
        end
        tests_run++;
        if (upd_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_upd_ready: got %b want 1", upd_ready);
        end
        tests_run++;
        if (disp_destination !== 8'h00 || stale !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL reset_disp_stale: got dest=%h stale=%b want 00/0", disp_destination, stale);
        end
    endtask

    task automatic test_accept();
        snap_t w;
        w = '{d: 8'h24, p: 26'h2A5_5A5A, s: 2'd1};
        applyStimulus(w);
        tests_run++;
        if (upd_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL accept_ready_low: got %b want 0", upd_ready);
        end
        applyStimulus('{d: 8'h77, p: 26'h000_1111, s: 2'd3});
        tests_run++;
        if (upd_ready !== 1'b0 || disp_destination !== exp_disp.d) begin
            tests_failed++;
            $display("[TB] FAIL pending_hold: got ready=%b dest=%h want 0/%h", upd_ready, disp_destination, exp_disp.d);
        end
        do_frame(1'b0, '0);
        tests_run++;
        if (pre_tick_dest !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL tick_cycle_dest: got %h want 00", pre_tick_dest);
        end
        tests_run++;
        if (disp_destination !== exp_disp.d || disp_people_data !== exp_disp.p || disp_sim_state !== exp_disp.s) begin
            tests_failed++;
            $display("[TB] FAIL commit_data: got %h/%h/%0d want %h/%h/%0d", disp_destination, disp_people_data,
                     disp_sim_state, exp_disp.d, exp_disp.p, exp_disp.s);
        end
        tests_run++;
        if (disp_valid !== 1'b1 || upd_ready !== 1'b1 || frame_count !== model_frames) begin
            tests_failed++;
            $display("[TB] FAIL commit_flags: got valid=%b ready=%b fc=%0d want 1/1/%0d", disp_valid, upd_ready,
                     frame_count, model_frames);
        end
    endtask

    task automatic test_same_cycle();
        do_frame(1'b1, '{d: 8'h01, p: 26'h123_4567, s: 2'd2});
        tests_run++;
        if (disp_destination !== exp_disp.d || upd_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL no_bypass: got dest=%h ready=%b want %h/0", disp_destination, upd_ready, exp_disp.d);
        end
        do_frame(1'b0, '0);
        tests_run++;
        if (disp_destination !== 8'h01 || disp_destination !== exp_disp.d || disp_people_data !== exp_disp.p) begin
            tests_failed++;
            $display("[TB] FAIL next_frame_commit: got %h/%h want %h/%h", disp_destination, disp_people_data,
                     exp_disp.d, exp_disp.p);
        end
    endtask

    task automatic test_stale();
        for (int i = 1; i <= 60; i++) begin
            do_frame(1'b0, '0);
            tests_run++;
            if (stale !== (model_stale_cnt >= 60)) begin
                tests_failed++;
                $display("[TB] FAIL stale_frame%0d: got %b want %b", i, stale, (model_stale_cnt >= 60));
            end
        end
        tests_run++;
        if (stale !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL stale_set: got %b want 1", stale);
        end
        applyStimulus('{d: 8'h5A, p: 26'h3FF_FFFF, s: 2'd0});
        do_frame(1'b0, '0);
        tests_run++;
        if (stale !== 1'b0 || disp_destination !== 8'h5A || disp_people_data !== 26'h3FF_FFFF) begin
            tests_failed++;
            $display("[TB] FAIL stale_clear: got stale=%b dest=%h ppl=%h want 0/5a/3ffffff", stale,
                     disp_destination, disp_people_data);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] start;
        start = model_frames;
        for (int i = 0; i < 256; i++) begin
            do_frame(1'b0, '0);
            tests_run++;
            if (frame_count !== model_frames || blink !== model_frames[3]) begin
                tests_failed++;
                $display("[TB] FAIL frame_blink%0d: got fc=%0d blink=%b want %0d/%b", i, frame_count, blink,
                         model_frames, model_frames[3]);
            end
        end
        tests_run++;
        if (frame_count !== start) begin
            tests_failed++;
            $display("[TB] FAIL frame_wrap: got %0d want %0d", frame_count, start);
        end
    endtask

    task automatic test_reset_pending();
        applyStimulus('{d: 8'hC3, p: 26'h0AB_CDEF, s: 2'd3});
        tests_run++;
        if (upd_ready !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL pend_before_reset: got %b want 0", upd_ready);
        end
        #2;
        nrst = 1'b0;
        model_reset();
        #1;
        tests_run++;
        if (upd_ready !== 1'b1 || disp_valid !== 1'b0 || stale !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_flags: got ready=%b valid=%b stale=%b want 1/0/0", upd_ready,
                     disp_valid, stale);
        end
        tests_run++;
        if (disp_destination !== 8'h00 || disp_people_data !== 26'h0 || disp_sim_state !== 2'd0 ||
            frame_count !== 8'd0 || blink !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL async_reset_data: got %h/%h/%0d fc=%0d want zeros", disp_destination,
                     disp_people_data, disp_sim_state, frame_count);
        end
        @(negedge clk);
        nrst = 1'b1;
        do_frame(1'b0, '0);
        do_frame(1'b0, '0);
        tests_run++;
        if (disp_valid !== exp_valid || disp_destination !== exp_disp.d || frame_count !== model_frames) begin
            tests_failed++;
            $display("[TB] FAIL shadow_discarded: got valid=%b dest=%h fc=%0d want %b/%h/%0d", disp_valid,
                     disp_destination, frame_count, exp_valid, exp_disp.d, model_frames);
        end
    endtask

    initial begin
        nrst        = 1'b0;
        upd_valid   = 1'b0;
        destination = '0;
        people_data = '0;
        sim_state   = '0;
        vsync       = 1'b0;
        test_reset();
        test_accept();
        test_same_cycle();
        test_stale();
        test_wrap();
        test_reset_pending();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
